// File: rtl/tmds_decoder.sv
// tmds_decoder: aligns one TMDS lane on blanking control tokens and decodes symbols to pixel/control data.
module tmds_decoder #(
  parameter int LOCK_COUNT = 8,
  parameter int TIMEOUT    = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] d_in,
  input  logic       realign,
  output logic       locked,
  output logic [3:0] offset,
  output logic       de,
  output logic [1:0] ctrl,
  output logic [7:0] data
);
  localparam int TW = $clog2(LOCK_COUNT + 1);
  localparam int RW = $clog2(TIMEOUT + 1);
  typedef enum logic {HUNT, LOCKED} state_t;
  state_t        state_q, state_d;
  logic [9:0]    d_prev_q, q_r_q, q;
  logic          hunt_r_q, tok, tok_r;
  logic [TW-1:0] tok_cnt_q, tok_cnt_d;
  logic [RW-1:0] run_cnt_q, run_cnt_d;
  logic [3:0]    offset_q, offset_d;
  logic          locked_q, locked_d, de_q, de_d;
  logic [1:0]    ctrl_q, ctrl_d;
  logic [7:0]    data_q, data_d, b, dec;
  function automatic logic is_tok(input logic [9:0] s);
    return s == 10'h354 || s == 10'h0AB || s == 10'h154 || s == 10'h2AB;
  endfunction
  function automatic logic [1:0] tok_val(input logic [9:0] s);
    return s == 10'h354 ? 2'b00 : s == 10'h0AB ? 2'b01 : s == 10'h154 ? 2'b10 : 2'b11;
  endfunction
  // older word sits at the LSB end, so shifting right by offset slides the symbol window
  assign q     = 10'({d_in, d_prev_q} >> offset_q);
  assign tok   = is_tok(q);
  assign tok_r = is_tok(q_r_q);
  always_comb begin
    state_d   = state_q;
    tok_cnt_d = tok_cnt_q;
    run_cnt_d = run_cnt_q;
    offset_d  = offset_q;
    locked_d  = locked_q;
    if (realign) begin
      state_d   = HUNT;
      locked_d  = 1'b0;
      tok_cnt_d = '0;
      run_cnt_d = '0;
    end else if (state_q == HUNT) begin
      run_cnt_d = '0;
      if (tok) begin
        tok_cnt_d = tok_cnt_q == TW'(LOCK_COUNT) ? tok_cnt_q : tok_cnt_q + TW'(1);
        if (tok_cnt_q == TW'(LOCK_COUNT - 1)) begin
          state_d  = LOCKED;
          locked_d = 1'b1;
        end
      end else begin
        tok_cnt_d = '0;
        offset_d  = offset_q == 4'd9 ? 4'd0 : offset_q + 4'd1;
      end
    end else begin
      run_cnt_d = tok ? '0 : run_cnt_q == RW'(TIMEOUT) ? run_cnt_q : run_cnt_q + RW'(1);
      if (!tok && run_cnt_q == RW'(TIMEOUT - 1)) begin
        state_d   = HUNT;
        locked_d  = 1'b0;
        tok_cnt_d = '0;
      end
    end
  end
  assign b      = q_r_q[9] ? ~q_r_q[7:0] : q_r_q[7:0];
  assign dec    = {q_r_q[8] ? b[7:1] ^ b[6:0] : ~(b[7:1] ^ b[6:0]), b[0]};
  assign de_d   = !hunt_r_q && !tok_r;
  assign data_d = de_d ? dec : 8'h00;
  assign ctrl_d = hunt_r_q ? 2'b00 : tok_r ? tok_val(q_r_q) : ctrl_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HUNT;
      d_prev_q  <= '0;
      q_r_q     <= '0;
      hunt_r_q  <= 1'b1;
      tok_cnt_q <= '0;
      run_cnt_q <= '0;
      offset_q  <= '0;
      locked_q  <= 1'b0;
      de_q      <= 1'b0;
      ctrl_q    <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      d_prev_q  <= d_in;
      q_r_q     <= q;
      hunt_r_q  <= state_q == HUNT;
      tok_cnt_q <= tok_cnt_d;
      run_cnt_q <= run_cnt_d;
      offset_q  <= offset_d;
      locked_q  <= locked_d;
      de_q      <= de_d;
      ctrl_q    <= ctrl_d;
      data_q    <= data_d;
    end
  end
  assign locked = locked_q;
  assign offset = offset_q;
  assign de     = de_q;
  assign ctrl   = ctrl_q;
  assign data   = data_q;
endmodule

// File: tb/tb_tmds_decoder.sv
// tb_tmds_decoder: directed vectors for the TMDS lane decoder, serial stream modelled with a fixed 3-bit slip.
module tb_tmds_decoder;
  logic       clk = 0, rst_n = 0, realign = 0;
  logic [9:0] d_in = '0;
  logic       locked, de;
  logic [3:0] offset;
  logic [1:0] ctrl;
  logic [7:0] data;
  tmds_decoder #(.LOCK_COUNT(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .d_in(d_in), .realign(realign),
    .locked(locked), .offset(offset), .de(de), .ctrl(ctrl), .data(data)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [9:0] sym;
    logic       de;
    logic [1:0] ctrl;
    logic [7:0] data;
  } vec_t;
  vec_t       tv[10];
  int         n_vec = 0, n_bad = 0;
  int         slip = 3;
  logic [9:0] prev = '0;
  logic       s_locked, s_de;
  logic [3:0] s_off;
  logic [1:0] s_ctrl;
  logic [7:0] s_data;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask
  // sample outputs left by previous edges, then drive the next serial word
  task automatic step(input logic [9:0] sym, input logic ra);
    logic [19:0] tmp;
    @(negedge clk);
    s_locked = locked; s_off = offset; s_de = de; s_ctrl = ctrl; s_data = data;
    tmp = ({10'b0, sym} << slip) | ({10'b0, prev} >> (10 - slip));
    d_in = tmp[9:0];
    prev = sym;
    realign = ra;
  endtask
  task automatic do_reset();
    rst_n = 0; d_in = '0; prev = '0; realign = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask
  task automatic lock_seq(input string tag);
    int m = -1;
    bit done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      step(10'h354, 1'b0);
      if (m < 0 && s_off == 4'd3) begin
        m = i;
        chk({tag, "_settle_step"}, m, 2);
      end
      if (m >= 0 && i == m + 7) chk({tag, "_locked_early"}, s_locked, 0);
      if (m >= 0 && i == m + 8) begin
        chk({tag, "_locked"}, s_locked, 1);
        chk({tag, "_offset"}, s_off, 3);
        chk({tag, "_de"}, s_de, 0);
        chk({tag, "_ctrl"}, s_ctrl, 0);
        done = 1;
      end
    end
    if (!done) chk({tag, "_lock_timeout"}, 0, 1);
  endtask
  initial begin
    tv[0] = '{10'h100, 1'b1, 2'b00, 8'h00};
    tv[1] = '{10'h2FF, 1'b1, 2'b00, 8'hFE};
    tv[2] = '{10'h2AB, 1'b0, 2'b11, 8'h00};
    tv[3] = '{10'h100, 1'b1, 2'b11, 8'h00};
    tv[4] = '{10'h1A5, 1'b1, 2'b11, 8'hEF};
    tv[5] = '{10'h0AB, 1'b0, 2'b01, 8'h00};
    tv[6] = '{10'h0A5, 1'b1, 2'b01, 8'h11};
    tv[7] = '{10'h154, 1'b0, 2'b10, 8'h00};
    tv[8] = '{10'h35A, 1'b1, 2'b10, 8'hEF};
    tv[9] = '{10'h354, 1'b0, 2'b00, 8'h00};
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(10'h000, 1'b0);
      chk("idle_offset", s_off, (i + 1) % 10);
      if (i == 0) chk("idle_outs", {s_locked, s_de, s_ctrl, s_data}, 0);
    end
    do_reset();
    lock_seq("lock");
    for (int i = 0; i < 13; i++) begin
      step(i < 10 ? tv[i].sym : 10'h354, 1'b0);
      if (i >= 3) begin
        chk($sformatf("vec%0d_de", i - 3), s_de, tv[i-3].de);
        chk($sformatf("vec%0d_ctrl", i - 3), s_ctrl, tv[i-3].ctrl);
        chk($sformatf("vec%0d_data", i - 3), s_data, tv[i-3].data);
        chk($sformatf("vec%0d_locked", i - 3), s_locked, 1);
      end
    end
    for (int i = 0; i < 18; i++) begin
      step(i < 15 ? 10'h100 : 10'h354, 1'b0);
      chk($sformatf("run15_locked%0d", i), s_locked, 1);
    end
    for (int i = 0; i < 34; i++) begin
      step(i < 16 ? 10'h100 : 10'h354, i == 24);
      chk($sformatf("to_locked%0d", i), s_locked, (i <= 16 || i >= 33));
      chk($sformatf("to_de%0d", i), s_de, (i >= 3 && i <= 18));
      chk($sformatf("to_offset%0d", i), s_off, 3);
    end
    for (int i = 0; i < 5; i++) step(10'h100, 1'b0);
    chk("pre_rst_de", de, 1);
    chk("pre_rst_locked", locked, 1);
    #2 rst_n = 0;
    #1 chk("mid_rst_outs", {locked, offset, de, ctrl, data}, 0);
    d_in = '0; prev = '0;
    @(negedge clk);
    rst_n = 1;
    lock_seq("relock");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
